// File: rtl/temp_monitor_pkg.sv
// Shared types and defaults for the temperature monitor.
package temp_mon_pkg;

    localparam int TEMP_W = 8;

    localparam int AVG_LOG2_DEF  = 3;
    localparam int HI_THRESH_DEF = 200;
    localparam int LO_THRESH_DEF = 180;
    localparam int DEBOUNCE_DEF  = 4;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        RISING  = 2'd1,
        ALARM   = 2'd2,
        FALLING = 2'd3
    } alarm_state_t;

endpackage

// File: rtl/temp_monitor_avg_window.sv
// Sliding window of the last 2^AVG_LOG2 accepted samples with a running sum.
// next_sum / next_full describe the window as it will be if the current
// sample is accepted, so the caller can act on the post-sample average.
module temp_avg_window
    import temp_mon_pkg::*;
#(
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_en,
    input  logic [TEMP_W-1:0]          temp,
    output logic [TEMP_W+AVG_LOG2-1:0] sum,
    output logic [TEMP_W+AVG_LOG2-1:0] next_sum,
    output logic                       full,
    output logic                       next_full
);

    localparam int W  = 1 << AVG_LOG2;
    localparam int SW = TEMP_W + AVG_LOG2;

    logic [TEMP_W-1:0]   mem_q [W];
    logic [AVG_LOG2-1:0] wr_ptr_q;
    logic [AVG_LOG2:0]   fill_q;
    logic [SW-1:0]       sum_q;
    logic [TEMP_W-1:0]   oldest;

    // Until the window is full the slot being overwritten holds no real sample.
    assign oldest    = fill_q[AVG_LOG2] ? mem_q[wr_ptr_q] : '0;
    // Intermediate may wrap; the final window sum always fits in SW bits.
    assign next_sum  = sum_q + SW'(temp) - SW'(oldest);
    assign next_full = fill_q[AVG_LOG2] | (fill_q == (AVG_LOG2+1)'(W - 1));
    assign sum       = sum_q;
    assign full      = fill_q[AVG_LOG2];

    // Sample storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (sample_en) begin
            mem_q[wr_ptr_q] <= temp;
        end
    end

    // Write pointer, fill count (saturates at W) and running sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            sum_q    <= '0;
        end else if (sample_en) begin
            wr_ptr_q <= wr_ptr_q + AVG_LOG2'(1);
            sum_q    <= next_sum;
            if (!fill_q[AVG_LOG2]) begin
                fill_q <= fill_q + (AVG_LOG2+1)'(1);
            end
        end
    end

endmodule

// File: rtl/temp_monitor.sv
// Temperature monitor: moving average, min/max statistics and a debounced
// over-temperature alarm with hysteresis.
// Optional min/max tracking is enabled by defining TEMP_MONITOR_MINMAX_EN.
module temp_monitor
    import temp_mon_pkg::*;
#(
    parameter int AVG_LOG2  = AVG_LOG2_DEF,
    parameter int HI_THRESH = HI_THRESH_DEF,
    parameter int LO_THRESH = LO_THRESH_DEF,
    parameter int DEBOUNCE  = DEBOUNCE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [TEMP_W-1:0] temp,
    input  logic              clear_stats,
    output logic [TEMP_W-1:0] avg,
    output logic              avg_valid,
    output logic [TEMP_W-1:0] min_temp,
    output logic [TEMP_W-1:0] max_temp,
    output logic              alarm,
    output logic [1:0]        alarm_state
);

    localparam int SW = TEMP_W + AVG_LOG2;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [TEMP_W-1:0] HI_T    = TEMP_W'(HI_THRESH);
    localparam logic [TEMP_W-1:0] LO_T    = TEMP_W'(LO_THRESH);
    localparam logic [CW-1:0]     DB_LAST = CW'(DEBOUNCE - 1);

    if (LO_THRESH >= HI_THRESH) begin : g_bad_thresh
        $error("temp_monitor: LO_THRESH must be below HI_THRESH");
    end
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("temp_monitor: DEBOUNCE must be at least 1");
    end

    logic [SW-1:0]     sum;
    logic [SW-1:0]     next_sum;
    logic              full;
    logic              next_full;
    logic [TEMP_W-1:0] next_avg;
    logic              over;
    logic              under;
    logic              step;

    alarm_state_t      state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cnt_inc;

    temp_avg_window #(.AVG_LOG2(AVG_LOG2)) u_window (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .temp      (temp),
        .sum       (sum),
        .next_sum  (next_sum),
        .full      (full),
        .next_full (next_full)
    );

    assign avg       = sum[SW-1:AVG_LOG2];
    assign avg_valid = full;
    assign next_avg  = next_sum[SW-1:AVG_LOG2];
    assign over      = next_avg > HI_T;
    assign under     = next_avg < LO_T;
    // Only full-window averages may move the alarm FSM.
    assign step      = sample_en & next_full;
    assign cnt_inc   = cnt_q + CW'(1);

    // Alarm state and debounce counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hysteresis FSM: in-band averages reset a pending debounce.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (step) begin
            unique case (state_q)
                NORMAL: begin
                    if (over) begin
                        if (DEBOUNCE == 1) begin
                            state_d = ALARM;
                        end else begin
                            state_d = RISING;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                RISING: begin
                    if (!over) begin
                        state_d = NORMAL;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = ALARM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ALARM: begin
                    if (under) begin
                        if (DEBOUNCE == 1) begin
                            state_d = NORMAL;
                        end else begin
                            state_d = FALLING;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                FALLING: begin
                    if (!under) begin
                        state_d = ALARM;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = NORMAL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign alarm       = (state_q == ALARM) || (state_q == FALLING);
    assign alarm_state = state_q;

`ifdef TEMP_MONITOR_MINMAX_EN
    logic [TEMP_W-1:0] min_q;
    logic [TEMP_W-1:0] max_q;

    // Min/max of accepted samples; a clear coinciding with a sample restarts from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            min_q <= 8'hFF;
            max_q <= 8'h00;
        end else if (clear_stats && sample_en) begin
            min_q <= temp;
            max_q <= temp;
        end else if (clear_stats) begin
            min_q <= 8'hFF;
            max_q <= 8'h00;
        end else if (sample_en) begin
            if (temp < min_q) min_q <= temp;
            if (temp > max_q) max_q <= temp;
        end
    end

    assign min_temp = min_q;
    assign max_temp = max_q;
`else
    logic unused_clear_stats;
    assign unused_clear_stats = clear_stats;
    assign min_temp = 8'hFF;
    assign max_temp = 8'h00;
`endif

endmodule

// File: tb/tb_temp_monitor.sv
module tb_temp_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_en = 1'b0;
    logic [7:0] temp = 8'd0;
    logic       clear_stats = 1'b0;
    logic [7:0] avg;
    logic       avg_valid;
    logic [7:0] min_temp;
    logic [7:0] max_temp;
    logic       alarm;
    logic [1:0] alarm_state;

    int errors = 0;
    int checks = 0;

`ifdef TEMP_MONITOR_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    temp_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .sample_en   (sample_en),
        .temp        (temp),
        .clear_stats (clear_stats),
        .avg         (avg),
        .avg_valid   (avg_valid),
        .min_temp    (min_temp),
        .max_temp    (max_temp),
        .alarm       (alarm),
        .alarm_state (alarm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic step(input logic rst, input logic en, input logic [7:0] t, input logic clr);
        @(negedge clk);
        reset = rst; sample_en = en; temp = t; clear_stats = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 8'd0, 1'b0);
        step(1'b1, 1'b0, 8'd0, 1'b0);
        checks++; if (avg !== 8'd0) begin errors++; $display("FAIL reset_avg: got %0d want 0", avg); end
        checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", avg_valid); end
        checks++; if (min_temp !== 8'hFF) begin errors++; $display("FAIL reset_min: got %h want FF", min_temp); end
        checks++; if (max_temp !== 8'h00) begin errors++; $display("FAIL reset_max: got %h want 00", max_temp); end
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b want 0", alarm); end
        checks++; if (alarm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", alarm_state); end
    endtask

    task automatic test_fill();
        logic [7:0] exp_avg [8] = '{8'd12, 8'd25, 8'd37, 8'd50, 8'd62, 8'd75, 8'd87, 8'd100};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'd100, 1'b0);
            checks++; if (avg !== exp_avg[i]) begin errors++; $display("FAIL fill_avg[%0d]: got %0d want %0d", i, avg, exp_avg[i]); end
            checks++; if (avg_valid !== (i == 7)) begin errors++; $display("FAIL fill_valid[%0d]: got %b want %b", i, avg_valid, (i == 7)); end
            checks++; if (alarm_state !== 2'd0) begin errors++; $display("FAIL fill_state[%0d]: got %0d want 0", i, alarm_state); end
        end
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL fill_alarm: got %b want 0", alarm); end
        checks++; if (min_temp !== (MM ? 8'd100 : 8'hFF)) begin errors++; $display("FAIL fill_min: got %0d want %0d", min_temp, (MM ? 8'd100 : 8'hFF)); end
        checks++; if (max_temp !== (MM ? 8'd100 : 8'h00)) begin errors++; $display("FAIL fill_max: got %0d want %0d", max_temp, (MM ? 8'd100 : 8'h00)); end
    endtask

    task automatic test_rise();
        logic [7:0] exp_avg [10] = '{8'd115, 8'd130, 8'd145, 8'd160, 8'd175, 8'd190, 8'd205, 8'd220, 8'd220, 8'd220};
        logic [1:0] exp_st  [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'd220, 1'b0);
            checks++; if (avg !== exp_avg[i]) begin errors++; $display("FAIL rise_avg[%0d]: got %0d want %0d", i, avg, exp_avg[i]); end
            checks++; if (alarm_state !== exp_st[i]) begin errors++; $display("FAIL rise_state[%0d]: got %0d want %0d", i, alarm_state, exp_st[i]); end
            checks++; if (alarm !== (i == 9)) begin errors++; $display("FAIL rise_alarm[%0d]: got %b want %b", i, alarm, (i == 9)); end
        end
    endtask

    task automatic test_fall();
        logic [7:0] hold_avg [8] = '{8'd216, 8'd212, 8'd208, 8'd205, 8'd201, 8'd197, 8'd193, 8'd190};
        logic [7:0] fall_avg [8] = '{8'd187, 8'd185, 8'd182, 8'd180, 8'd177, 8'd175, 8'd172, 8'd170};
        logic [1:0] fall_st  [8] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'd190, 1'b0);
            checks++; if (avg !== hold_avg[i]) begin errors++; $display("FAIL hold_avg[%0d]: got %0d want %0d", i, avg, hold_avg[i]); end
            checks++; if (alarm !== 1'b1 || alarm_state !== 2'd2) begin errors++; $display("FAIL hold_alarm[%0d]: got alarm=%b state=%0d want alarm=1 state=2", i, alarm, alarm_state); end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'd170, 1'b0);
            checks++; if (avg !== fall_avg[i]) begin errors++; $display("FAIL fall_avg[%0d]: got %0d want %0d", i, avg, fall_avg[i]); end
            checks++; if (alarm_state !== fall_st[i]) begin errors++; $display("FAIL fall_state[%0d]: got %0d want %0d", i, alarm_state, fall_st[i]); end
            checks++; if (alarm !== (i != 7)) begin errors++; $display("FAIL fall_alarm[%0d]: got %b want %b", i, alarm, (i != 7)); end
        end
    endtask

    task automatic test_rising_abort();
        logic [7:0] re_avg [4] = '{8'd201, 8'd202, 8'd203, 8'd204};
        logic [1:0] re_st  [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
        step(1'b1, 1'b0, 8'd0, 1'b0);
        // window fills with 220: state goes RISING at the 8th, cnt reaches 3 at the 10th
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'd220, 1'b0);
            checks++; if (alarm_state !== ((i >= 7) ? 2'd1 : 2'd0)) begin errors++; $display("FAIL abort_pre_state[%0d]: got %0d want %0d", i, alarm_state, ((i >= 7) ? 2'd1 : 2'd0)); end
        end
        step(1'b0, 1'b1, 8'd60, 1'b0);
        checks++; if (avg !== 8'd200) begin errors++; $display("FAIL abort_avg: got %0d want 200", avg); end
        checks++; if (alarm_state !== 2'd0 || alarm !== 1'b0) begin errors++; $display("FAIL abort_state: got state=%0d alarm=%b want state=0 alarm=0", alarm_state, alarm); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'd228, 1'b0);
            checks++; if (avg !== re_avg[i]) begin errors++; $display("FAIL rearm_avg[%0d]: got %0d want %0d", i, avg, re_avg[i]); end
            checks++; if (alarm_state !== re_st[i]) begin errors++; $display("FAIL rearm_state[%0d]: got %0d want %0d", i, alarm_state, re_st[i]); end
            checks++; if (alarm !== (i == 3)) begin errors++; $display("FAIL rearm_alarm[%0d]: got %b want %b", i, alarm, (i == 3)); end
        end
    endtask

    task automatic test_reset_mid_alarm();
        step(1'b1, 1'b1, 8'd255, 1'b0);
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL rst_alarm: got %b want 0", alarm); end
        checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", avg_valid); end
        checks++; if (avg !== 8'd0) begin errors++; $display("FAIL rst_avg: got %0d want 0", avg); end
        checks++; if (alarm_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", alarm_state); end
        checks++; if (min_temp !== 8'hFF || max_temp !== 8'h00) begin errors++; $display("FAIL rst_minmax: got %h/%h want FF/00", min_temp, max_temp); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'd250, 1'b0);
            checks++; if (avg_valid !== (i == 7)) begin errors++; $display("FAIL refill_valid[%0d]: got %b want %b", i, avg_valid, (i == 7)); end
            checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL refill_alarm[%0d]: got %b want 0", i, alarm); end
            checks++; if (alarm_state !== ((i == 7) ? 2'd1 : 2'd0)) begin errors++; $display("FAIL refill_state[%0d]: got %0d want %0d", i, alarm_state, ((i == 7) ? 2'd1 : 2'd0)); end
        end
        checks++; if (avg !== 8'd250) begin errors++; $display("FAIL refill_avg: got %0d want 250", avg); end
    endtask

    task automatic test_minmax();
        logic [7:0] smp  [3] = '{8'd50, 8'd240, 8'd90};
        logic [7:0] emin [3] = '{8'd50, 8'd50, 8'd50};
        logic [7:0] emax [3] = '{8'd50, 8'd240, 8'd240};
        step(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, smp[i], 1'b0);
            checks++; if (min_temp !== (MM ? emin[i] : 8'hFF)) begin errors++; $display("FAIL mm_min[%0d]: got %0d want %0d", i, min_temp, (MM ? emin[i] : 8'hFF)); end
            checks++; if (max_temp !== (MM ? emax[i] : 8'h00)) begin errors++; $display("FAIL mm_max[%0d]: got %0d want %0d", i, max_temp, (MM ? emax[i] : 8'h00)); end
        end
        step(1'b0, 1'b1, 8'd120, 1'b1);
        checks++; if (min_temp !== (MM ? 8'd120 : 8'hFF) || max_temp !== (MM ? 8'd120 : 8'h00)) begin errors++; $display("FAIL mm_clear_load: got %0d/%0d", min_temp, max_temp); end
        step(1'b0, 1'b0, 8'd5, 1'b1);
        checks++; if (min_temp !== 8'hFF || max_temp !== 8'h00) begin errors++; $display("FAIL mm_clear_only: got %h/%h want FF/00", min_temp, max_temp); end
        step(1'b0, 1'b1, 8'd77, 1'b0);
        checks++; if (min_temp !== (MM ? 8'd77 : 8'hFF) || max_temp !== (MM ? 8'd77 : 8'h00)) begin errors++; $display("FAIL mm_after_clear: got %0d/%0d", min_temp, max_temp); end
        // partial window: 50+240+90+120+77 = 577, /8 = 72
        checks++; if (avg !== 8'd72 || avg_valid !== 1'b0) begin errors++; $display("FAIL mm_avg: got %0d valid=%b want 72 valid=0", avg, avg_valid); end
        step(1'b0, 1'b0, 8'd3, 1'b0);
        checks++; if (avg !== 8'd72 || min_temp !== (MM ? 8'd77 : 8'hFF)) begin errors++; $display("FAIL idle_hold: got avg=%0d min=%0d", avg, min_temp); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_rise();
        test_fall();
        test_rising_abort();
        test_reset_mid_alarm();
        test_minmax();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
